// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: op encoding, per-stage flag bundle
// and the single-bit op kernel replicated across the datapath width.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NAND   = 3'd2,
        OP_NOR    = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    // Result flags carried alongside the data word through every stage.
    typedef struct packed {
        logic zero;
        logic ones;
        logic parity;
    } flags_t;

    localparam int FLAGS_W = $bits(flags_t);

    // Bitwise kernel; the top replicates it once per result bit, so any WIDTH works.
    function automatic logic apply_op(input op_e op, input logic a, input logic b);
        logic r;
        r = 1'b0;
        case (op)
            OP_AND:    r = a & b;
            OP_OR:     r = a | b;
            OP_NAND:   r = ~(a & b);
            OP_NOR:    r = ~(a | b);
            OP_XOR:    r = a ^ b;
            OP_XNOR:   r = ~(a ^ b);
            OP_NOT_A:  r = ~a;
            OP_PASS_A: r = a;
            default:   r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_unit_stage.sv
// One valid/ready pipeline register: loads whenever it is empty or its
// downstream neighbour is taking the current beat.
module logic_unit_stage #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    input  logic [PW-1:0] up_data,
    input  logic          down_ready,
    output logic          valid,
    output logic [PW-1:0] data
);

    logic          valid_reg;
    logic [PW-1:0] data_reg;
    logic          load;

    assign load = !valid_reg || down_ready;

    // Payload only moves with a real beat, so a bubble never disturbs held data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (load) begin
            valid_reg <= up_valid;
            if (up_valid) begin
                data_reg <= up_data;
            end
        end
    end

    assign valid = valid_reg;
    assign data  = data_reg;

endmodule

// File: rtl/logic_unit_pipe.sv
// Width-generic bitwise logic unit with STAGES handshake register stages,
// registered result flags and a wrapping completed-transfer counter.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity,
    output logic [CNT_W-1:0] done_cnt
);

    localparam int PW = WIDTH + FLAGS_W;

    op_e              op_sel;
    logic [WIDTH-1:0] result_next;
    flags_t           flags_next;

    logic [STAGES-1:0] stage_valid;
    logic [STAGES:0]   stage_ready;
    logic [STAGES-1:0] up_valid;
    logic [PW-1:0]     up_data    [STAGES];
    logic [PW-1:0]     stage_data [STAGES];

    flags_t           out_flags;
    logic [CNT_W-1:0] done_cnt_reg;

    assign op_sel = op_e'(in_op);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_bit
            assign result_next[gi] = apply_op(op_sel, in_a[gi], in_b[gi]);
        end
    endgenerate

    always_comb begin
        flags_next        = '0;
        flags_next.zero   = ~|result_next;
        flags_next.ones   = &result_next;
        flags_next.parity = ^result_next;
    end

    // Stage i can load unless it and every stage after it are full and the
    // output is stalled; written in closed form to keep the ready path acyclic.
    generate
        for (gi = 0; gi <= STAGES; gi++) begin : gen_ready
            if (gi == STAGES) begin : g_last
                assign stage_ready[gi] = out_ready;
            end else begin : g_mid
                assign stage_ready[gi] = out_ready || !(&stage_valid[STAGES-1:gi]);
            end
        end
    endgenerate

    assign in_ready = stage_ready[0];

    generate
        for (gi = 0; gi < STAGES; gi++) begin : gen_stage
            if (gi == 0) begin : g_head
                assign up_valid[gi] = in_valid;
                assign up_data[gi]  = {result_next, flags_next};
            end else begin : g_body
                assign up_valid[gi] = stage_valid[gi-1];
                assign up_data[gi]  = stage_data[gi-1];
            end

            logic_unit_stage #(
                .PW (PW)
            ) u_stage (
                .clk        (clk),
                .rst        (rst),
                .up_valid   (up_valid[gi]),
                .up_data    (up_data[gi]),
                .down_ready (stage_ready[gi+1]),
                .valid      (stage_valid[gi]),
                .data       (stage_data[gi])
            );
        end
    endgenerate

    assign out_valid             = stage_valid[STAGES-1];
    assign {out_data, out_flags} = stage_data[STAGES-1];
    assign out_zero              = out_flags.zero;
    assign out_ones              = out_flags.ones;
    assign out_parity            = out_flags.parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_cnt_reg <= '0;
        end else if (out_valid && out_ready) begin
            done_cnt_reg <= done_cnt_reg + CNT_W'(1);
        end
    end

    assign done_cnt = done_cnt_reg;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised, self-checking bench for logic_unit_pipe (WIDTH=8, STAGES=2, CNT_W=4)
// against a queue-based reference model of the unit's observable behaviour.
module tb_logic_unit_pipe;

    localparam int W  = 8;
    localparam int S  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_op;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic          out_zero;
    logic          out_ones;
    logic          out_parity;
    logic [CW-1:0] done_cnt;

    always #5 clk = ~clk;

    logic_unit_pipe #(
        .WIDTH  (W),
        .STAGES (S),
        .CNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_ones   (out_ones),
        .out_parity (out_parity),
        .done_cnt   (done_cnt)
    );

    typedef struct {
        logic [W-1:0] d;
        logic         z;
        logic         o;
        logic         p;
        int           cyc;
    } beat_t;

    beat_t exp_q[$];
    int    checks  = 0;
    int    errors  = 0;
    int    cyc     = 0;
    int    n_out   = 0;
    bit    lat_chk = 1'b0;

    function automatic logic [W-1:0] ref_result(input logic [2:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic beat_t ref_beat(input logic [2:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b, input int c);
        beat_t r;
        r.d   = ref_result(op, a, b);
        r.z   = (r.d == '0);
        r.o   = (r.d == {W{1'b1}});
        r.p   = ($countones(r.d) % 2) == 1;
        r.cyc = c;
        return r;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Scoreboard: in_ready against model occupancy, in-order result checks,
    // latency when enabled, and hold-stability during output stalls.
    initial begin : scoreboard
        beat_t       e;
        logic        stall_prev;
        logic [11:0] prev_out;
        logic        exp_rdy;
        stall_prev = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall_prev = 1'b0;
            end else begin
                exp_rdy = (exp_q.size() < S) || out_ready;
                checks++;
                if (in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL sb_in_ready: cycle %0d got %b expected %b", cyc, in_ready, exp_rdy);
                end
                if (stall_prev) begin
                    checks++;
                    if ({out_valid, out_data, out_zero, out_ones, out_parity} !== prev_out) begin
                        errors++;
                        $display("FAIL sb_hold: cycle %0d got %h expected %h", cyc,
                                 {out_valid, out_data, out_zero, out_ones, out_parity}, prev_out);
                    end
                end
                if (out_valid && out_ready) begin
                    n_out++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: cycle %0d got beat %h expected none", cyc, out_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_data, out_zero, out_ones, out_parity} !== {e.d, e.z, e.o, e.p}) begin
                            errors++;
                            $display("FAIL sb_data: cycle %0d got %h z%b o%b p%b expected %h z%b o%b p%b",
                                     cyc, out_data, out_zero, out_ones, out_parity, e.d, e.z, e.o, e.p);
                        end
                        if (lat_chk) begin
                            checks++;
                            if (cyc - e.cyc != S) begin
                                errors++;
                                $display("FAIL sb_latency: got %0d expected %0d", cyc - e.cyc, S);
                            end
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_out   = {out_valid, out_data, out_zero, out_ones, out_parity};
                if (in_valid && in_ready) begin
                    exp_q.push_back(ref_beat(in_op, in_a, in_b, cyc));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send_beat(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int   n;
        logic acc;
        n        = 0;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: got no in_ready in %0d cycles expected acceptance", n);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({out_valid, out_data, out_zero, out_ones, out_parity, done_cnt, in_ready} !==
            {1'b0, 8'h00, 3'b000, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_state: got v%b d%h f%b%b%b cnt%0d rdy%b expected v0 d00 f000 cnt0 rdy1",
                     out_valid, out_data, out_zero, out_ones, out_parity, done_cnt, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got v%b rdy%b expected v0 rdy1", out_valid, in_ready);
        end
    endtask

    task automatic test_op_sweep();
        logic [2:0] ops   [5] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd7};
        logic [7:0] va    [5] = '{8'hF0, 8'hFF, 8'h00, 8'h01, 8'hA5};
        logic [7:0] vb    [5] = '{8'h3C, 8'hFF, 8'h00, 8'h00, 8'h5A};
        logic [7:0] ed    [5] = '{8'h30, 8'h00, 8'hFF, 8'hFE, 8'hA5};
        logic [2:0] ef    [5] = '{3'b000, 3'b100, 3'b010, 3'b001, 3'b000};
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1;
            in_op    = ops[k];
            in_a     = va[k];
            in_b     = vb[k];
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL op_early[%0d]: got out_valid %b one cycle after accept expected 0", k, out_valid);
            end
            @(posedge clk);
            #1;
            checks++;
            if ({out_valid, out_data, out_zero, out_ones, out_parity} !== {1'b1, ed[k], ef[k]}) begin
                errors++;
                $display("FAIL op_vec[%0d]: got v%b %h f%b%b%b expected v1 %h f%b", k, out_valid,
                         out_data, out_zero, out_ones, out_parity, ed[k], ef[k]);
            end
            idle(1);
        end
        for (int k = 0; k < 30; k++) begin
            send_beat(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL op_drain: got %0d beats outstanding expected 0", exp_q.size());
        end
        lat_chk = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n0;
        int run;
        int best;
        n0        = n_out;
        run       = 0;
        best      = 0;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int k = 0; k < 12; k++) begin
            in_valid = (k < 8);
            in_op    = 3'(k);
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(negedge clk);
            if (k < 8) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", k, in_ready);
                end
            end
            if (out_valid) begin
                run++;
                if (run > best) best = run;
            end else begin
                run = 0;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (best != 8 || n_out - n0 != 8) begin
            errors++;
            $display("FAIL b2b_stream: got run %0d total %0d expected run 8 total 8", best, n_out - n0);
        end
        lat_chk = 1'b0;
    endtask

    task automatic test_backpressure();
        int           n0;
        logic [W-1:0] held;
        do_reset();
        n0        = n_out;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_op    = 3'($urandom_range(0, 7));
            in_a     = 8'($urandom);
            in_b     = 8'($urandom);
            @(negedge clk);
            checks++;
            if (in_ready !== (k < 2)) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b expected %b", k, in_ready, k < 2);
            end
            @(posedge clk);
            #1;
        end
        held = out_data;
        idle(2);
        checks++;
        if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: got v%b %h rdy%b expected v1 %h rdy0", out_valid, out_data, in_ready, held);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got out_valid %b expected 1", k, out_valid);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        idle(1);
        checks++;
        if (done_cnt !== 4'd3 || n_out - n0 != 3 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_count: got cnt %0d xfers %0d v%b expected cnt 3 xfers 3 v0",
                     done_cnt, n_out - n0, out_valid);
        end
    endtask

    task automatic test_counter_wrap();
        int n0;
        do_reset();
        n0        = n_out;
        out_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            send_beat(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
        end
        idle(4);
        checks++;
        if (done_cnt !== 4'd1 || n_out - n0 != 17) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt %0d xfers %0d expected cnt 1 xfers 17", done_cnt, n_out - n0);
        end
    endtask

    task automatic test_reset_midflight();
        int n0;
        out_ready = 1'b1;
        send_beat(3'd4, 8'($urandom), 8'($urandom));
        send_beat(3'd1, 8'($urandom), 8'($urandom));
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        n0 = n_out;
        checks++;
        if (out_valid !== 1'b0 || done_cnt !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: got v%b cnt %0d expected v0 cnt 0", out_valid, done_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        checks++;
        if (n_out != n0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale: got %0d transfers v%b expected 0 transfers v0", n_out - n0, out_valid);
        end
        lat_chk = 1'b1;
        send_beat(3'd5, 8'($urandom), 8'($urandom));
        idle(3);
        checks++;
        if (n_out - n0 != 1 || exp_q.size() != 0 || done_cnt !== 4'd1) begin
            errors++;
            $display("FAIL rst_recover: got %0d transfers cnt %0d expected 1 transfer cnt 1",
                     n_out - n0, done_cnt);
        end
        lat_chk = 1'b0;
    endtask

    task automatic test_bubble();
        int n0;
        n0        = n_out;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd0;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_op     = 3'd3;
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ready = k[0];
            @(posedge clk);
            #1;
        end
        checks++;
        if (n_out - n0 != 2 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL bubble: got %0d transfers %0d outstanding expected 2 transfers 0 outstanding",
                     n_out - n0, exp_q.size());
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom_range(0, 7));
            in_a      = 8'($urandom);
            in_b      = 8'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        idle(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL random_drain: got %0d beats outstanding expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_op_sweep();
        test_back_to_back();
        test_backpressure();
        test_counter_wrap();
        test_reset_midflight();
        test_bubble();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined bitwise logic unit. It applies one of eight selectable two-operand logic ops to WIDTH-bit operands and registers the result through STAGES pipeline stages. Each stage uses a valid/ready handshake. The unit also produces result flags and a count of completed transfers. It is the clocked, width-generic successor to the team's single-bit combinational gate block and serves as a reusable datapath element.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
STAGES, 2, number of pipeline register stages (1..4)
CNT_W, 16, width of completed-transfer counter

Ports:
clk  in  1  clock, rising-edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept beat this cycle
in_op  in  3  operation select (op_e)
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B (ignored for NOT_A/PASS_A)
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
out_data  out  WIDTH  result
out_zero  out  1  result == 0
out_ones  out  1  result == all ones
out_parity  out  1  XOR-reduction of result
done_cnt  out  CNT_W  completed output transfers, modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock clk. Reset rst is asynchronous, active-high.
- Ops (in_op): 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A (~a), 7 PASS_A (a). All codes are defined; no illegal op.
- Datapath:
  - Result and flags are computed combinationally from in_a/in_b/in_op.
  - They are captured into stage 0 on an input transfer (in_valid && in_ready).
  - Flags travel with the data through every stage.
- Stage handshake:
  - Stage i holds valid[i] plus payload (data, zero, ones, parity).
  - Stage i loads when !valid[i] || ready[i+1]. Stage STAGES-1 uses out_ready as ready[i+1].
  - in_ready = load condition of stage 0. This is combinational from out_ready back through the full-stage chain; no skid buffer.
  - On load, valid[i] takes the upstream valid. A stage with valid=0 is a bubble, and bubbles are collapsed.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready=1. Throughput is one beat per cycle.
- Backpressure:
  - While out_valid && !out_ready, out_data and all flags hold stable.
  - Beats keep filling empty upstream stages.
  - in_ready falls only when every stage holds a valid beat.
- Ordering: strict in-order; no beat is dropped or duplicated.
- Outputs: out_valid = valid[STAGES-1]. out_data and flags are registered.
- done_cnt: increments by 1 on each out_valid && out_ready and wraps from 2^CNT_W-1 to 0.
- Reset values: all valid bits 0, out_valid 0, out_data 0, out_zero 0, out_ones 0, out_parity 0, done_cnt 0. in_ready is therefore 1 immediately after reset.
- Reset mid-operation: in-flight beats are discarded with no output transfer. done_cnt clears.
- Simultaneous in and out transfer with a full pipeline: the pipeline shifts, the new beat is accepted and occupancy is unchanged.
- WIDTH=1: out_parity equals out_data, and out_zero == !out_ones.

Decomposition:
- Package logic_unit_pkg:
  - typedef enum logic [2:0] op_e with the eight op codes.
  - Function apply_op(op_e, a, b) that is width-generic through a parameterised class or the WIDTH argument pattern already in use.
  - Typedef of the stage payload struct fields, without WIDTH-dependent packing outside the module.
- Sub-module logic_unit_stage: one handshake register stage (valid, payload, load logic). It is instantiated STAGES times via generate.
- Flag computation and the counter live in the top module.

Test Plan:
All scenarios use WIDTH=8, STAGES=2, CNT_W=4.
1. Op sweep, out_ready=1:
   - AND F0,3C -> 30, zero=0, ones=0, parity=0
   - XOR FF,FF -> 00, zero=1
   - NAND 00,00 -> FF, ones=1, parity=0
   - NOT_A 01 -> FE, parity=1
   - PASS_A A5 -> A5
   - Every result appears exactly 2 cycles after acceptance.
2. Back-to-back streaming of 8 beats (one per op) with out_ready=1 -> 8 consecutive out_valid cycles, in order, in_ready held at 1.
3. Backpressure:
   - Hold out_ready=0 and offer 3 beats -> first 2 accepted, in_ready=0 on the third, out_data stable.
   - Raise out_ready -> 3 results on consecutive cycles, in order, done_cnt=3.
4. Counter wrap: 17 completed transfers -> done_cnt=1.
5. Reset mid-flight:
   - Assert rst asynchronously (between clock edges) with 2 beats in the pipe -> out_valid=0, done_cnt=0 immediately, no stale beat after release.
   - Next beat returns normally after 2 cycles.
6. Bubble collapse: in_valid pattern 1,0,1 with out_ready toggling 0,1 -> two beats delivered in order, none duplicated.
